shru_save_sequencer: RTL and testbench

Sequences the shadow-register save frame (mepc, mcause and other snapshot words) into the data cache on an interrupt save trigger from the issue stage. It shares the single dcache store port between the LSU and the ShRU, and tracks the nesting level of saved frames. It also flags LSU load page offsets that hit an in-flight frame. It sits between issue_read_operands/ShRU and the dcache store request port.

---
 rtl/shru_seq_pkg.sv | 24 ++
 rtl/shru_page_match.sv | 37 +++
 rtl/shru_save_sequencer.sv | 173 +++++++++++++++++
 tb/tb_shru_save_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shru_seq_pkg.sv
// shru_seq_pkg: shared types and helpers for the ShRU save-frame sequencer.
//   state_e      - sequencer FSM states
//   NR_WORDS     - default number of words in one save frame
//   MEPC_IDX     - frame word holding mepc
//   MCAUSE_IDX   - frame word holding mcause
//   word_offset  - byte offset of frame word idx for a given XLEN
package shru_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SAVE = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned NR_WORDS   = 4;
  localparam int unsigned MEPC_IDX   = 0;
  localparam int unsigned MCAUSE_IDX = 1;

  function automatic int unsigned word_offset(input int unsigned idx, input int unsigned xlen);
    return idx * (xlen / 8);
  endfunction

endpackage

// File: rtl/shru_page_match.sv
// shru_page_match: flags an LSU load page offset that lands in the same
// XLEN-sized slot as any word of the active save frame.
// Ports:
//   active_i      - a frame is in flight (sequencer busy)
//   base_i        - low 12 bits of the frame base address
//   page_offset_i - LSU load page offset
//   match_o       - offset overlaps one of the NR_WORDS frame words
module shru_page_match
  import shru_seq_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NR_WORDS = 4
) (
  input  logic        active_i,
  input  logic [11:0] base_i,
  input  logic [11:0] page_offset_i,
  output logic        match_o
);

  // Word granularity: 8-byte slots for RV64, 4-byte slots for RV32.
  localparam int unsigned LSB = (XLEN == 32) ? 2 : 3;

  logic [11:0] word_addr;

  always_comb begin
    match_o   = 1'b0;
    word_addr = '0;
    for (int unsigned i = 0; i < NR_WORDS; i++) begin
      // Only the page offset matters, so the sum wraps within 12 bits.
      word_addr = base_i + 12'(word_offset(i, XLEN));
      if ((page_offset_i >> LSB) == (word_addr >> LSB)) begin
        match_o = active_i;
      end
    end
  end

endmodule

// File: rtl/shru_save_sequencer.sv
// shru_save_sequencer: writes the shadow-register save frame (mepc, mcause,
// further snapshot words) below the current sp through the shared dcache
// store port, arbitrating that port against the LSU, and tracks the number
// of nested saved frames.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   save_req_i/save_sp_i/save_data_i - save trigger pulse, sp, snapshot words
//   restore_i               - frame popped (mret) pulse
//   save_ready_o            - a save trigger will be accepted this cycle
//   next_sp_o               - sp after the frame is pushed (combinational)
//   level_o                 - current nesting level
//   store_valid_o           - one-cycle pulse once the whole frame is granted
//   busy_o, overflow_o      - FSM not idle; sticky save-at-max-level flag
//   lsu_*                   - LSU store request side
//   mem_*                   - dcache store request side
//   page_offset_i/page_offset_match_o - load offset vs. in-flight frame
//   perf_lsu_stall_o        - LSU cycles blocked by a save
//   state_o                 - FSM state, for debug and checkers
// Build option: define SHRU_SEQ_PERF_EN to build the LSU stall counter;
// otherwise perf_lsu_stall_o is tied to zero.
//
// Handshake: a dcache request (mem_req_o with addr/wdata/be) is held stable
// until the cycle mem_gnt_i is high; that cycle completes the transfer. The
// LSU obeys the same rule on lsu_req_i/lsu_gnt_o.
module shru_save_sequencer
  import shru_seq_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned NR_WORDS  = 4,
  parameter int unsigned MAX_LEVEL = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     save_req_i,
  input  logic [XLEN-1:0]          save_sp_i,
  input  logic [NR_WORDS*XLEN-1:0] save_data_i,
  input  logic                     restore_i,
  output logic                     save_ready_o,
  output logic [XLEN-1:0]          next_sp_o,
  output logic [4:0]               level_o,
  output logic                     store_valid_o,
  output logic                     busy_o,
  output logic                     overflow_o,
  input  logic                     lsu_req_i,
  input  logic [XLEN-1:0]          lsu_addr_i,
  input  logic [XLEN-1:0]          lsu_wdata_i,
  input  logic [XLEN/8-1:0]        lsu_be_i,
  output logic                     lsu_gnt_o,
  output logic                     mem_req_o,
  output logic [XLEN-1:0]          mem_addr_o,
  output logic [XLEN-1:0]          mem_wdata_o,
  output logic [XLEN/8-1:0]        mem_be_o,
  input  logic                     mem_gnt_i,
  input  logic [11:0]              page_offset_i,
  output logic                     page_offset_match_o,
  output logic [31:0]              perf_lsu_stall_o,
  output state_e                   state_o
);

  localparam int unsigned CNT_W = (NR_WORDS > 1) ? $clog2(NR_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NR_WORDS - 1);
  localparam logic [4:0] MAX_LVL = 5'(MAX_LEVEL);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q;
  logic [4:0]                   level_q;
  logic                         overflow_q;
  logic [XLEN-1:0]              base_q;
  logic [NR_WORDS-1:0][XLEN-1:0] words_q;
  logic                         accept;
  logic                         grant_save;
  logic                         level_inc;
  logic                         level_dec;

  assign next_sp_o    = save_sp_i - XLEN'(word_offset(NR_WORDS, XLEN));
  assign save_ready_o = (state_q == ST_IDLE) && (level_q < MAX_LVL);
  assign accept       = save_req_i && save_ready_o;
  assign grant_save   = (state_q == ST_SAVE) && mem_gnt_i;
  assign level_inc    = (state_q == ST_DONE);
  assign level_dec    = restore_i && (level_q != 5'd0);

  assign busy_o     = (state_q != ST_IDLE);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign state_o    = state_q;

  always_comb begin
    state_d       = state_q;
    store_valid_o = 1'b0;
    // LSU passthrough unless the frame owns the port.
    mem_req_o     = lsu_req_i;
    mem_addr_o    = lsu_addr_i;
    mem_wdata_o   = lsu_wdata_i;
    mem_be_o      = lsu_be_i;
    lsu_gnt_o     = lsu_req_i & mem_gnt_i;
    case (state_q)
      ST_IDLE: begin
        // A stalled LSU request must finish first, so it cannot be torn.
        if (accept) state_d = (lsu_req_i && !mem_gnt_i) ? ST_PEND : ST_SAVE;
      end
      ST_PEND: begin
        if (!lsu_req_i || mem_gnt_i) state_d = ST_SAVE;
      end
      ST_SAVE: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = base_q + XLEN'(word_offset(32'(cnt_q), XLEN));
        mem_wdata_o = words_q[cnt_q];
        mem_be_o    = '1;
        lsu_gnt_o   = 1'b0;
        if (mem_gnt_i && (cnt_q == LAST_CNT)) state_d = ST_DONE;
      end
      ST_DONE: begin
        store_valid_o = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      base_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q  <= next_sp_o;
        words_q <= save_data_i;
        cnt_q   <= '0;
      end else if (grant_save) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // A push and a pop in the same cycle cancel out.
      case ({level_inc, level_dec})
        2'b10:   level_q <= level_q + 5'd1;
        2'b01:   level_q <= level_q - 5'd1;
        default: level_q <= level_q;
      endcase
      if (save_req_i && (level_q == MAX_LVL)) overflow_q <= 1'b1;
    end
  end

  shru_page_match #(
    .XLEN     (XLEN),
    .NR_WORDS (NR_WORDS)
  ) u_page_match (
    .active_i      (busy_o),
    .base_i        (base_q[11:0]),
    .page_offset_i (page_offset_i),
    .match_o       (page_offset_match_o)
  );

`ifdef SHRU_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (lsu_req_i && (state_q == ST_SAVE) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_lsu_stall_o = perf_q;
`else
  assign perf_lsu_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_shru_save_sequencer.sv
// tb_shru_save_sequencer: randomized bench with a transfer scoreboard for
// shru_save_sequencer. Every expected dcache transfer is queued when the
// stimulus is issued; a negedge monitor pops and compares each granted one.
module tb_shru_save_sequencer;
  import shru_seq_pkg::*;

  localparam int XLEN = 64;
  localparam int NW   = 4;
  localparam int MAXL = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 save_req_i;
  logic [XLEN-1:0]      save_sp_i;
  logic [NW*XLEN-1:0]   save_data_i;
  logic                 restore_i;
  logic                 save_ready_o;
  logic [XLEN-1:0]      next_sp_o;
  logic [4:0]           level_o;
  logic                 store_valid_o;
  logic                 busy_o;
  logic                 overflow_o;
  logic                 lsu_req_i;
  logic [XLEN-1:0]      lsu_addr_i;
  logic [XLEN-1:0]      lsu_wdata_i;
  logic [XLEN/8-1:0]    lsu_be_i;
  logic                 lsu_gnt_o;
  logic                 mem_req_o;
  logic [XLEN-1:0]      mem_addr_o;
  logic [XLEN-1:0]      mem_wdata_o;
  logic [XLEN/8-1:0]    mem_be_o;
  logic                 mem_gnt_i;
  logic [11:0]          page_offset_i;
  logic                 page_offset_match_o;
  logic [31:0]          perf_lsu_stall_o;
  state_e               state_o;

  shru_save_sequencer #(.XLEN(XLEN), .NR_WORDS(NW), .MAX_LEVEL(MAXL)) dut (
    .clk_i(clk), .rst_i(rst),
    .save_req_i(save_req_i), .save_sp_i(save_sp_i), .save_data_i(save_data_i),
    .restore_i(restore_i), .save_ready_o(save_ready_o), .next_sp_o(next_sp_o),
    .level_o(level_o), .store_valid_o(store_valid_o), .busy_o(busy_o),
    .overflow_o(overflow_o),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_be_i(lsu_be_i), .lsu_gnt_o(lsu_gnt_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .page_offset_i(page_offset_i), .page_offset_match_o(page_offset_match_o),
    .perf_lsu_stall_o(perf_lsu_stall_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [XLEN+XLEN+XLEN/8-1:0] exp_q[$];
  logic [XLEN+XLEN+XLEN/8-1:0] mon_e;
  int sv_count  = 0;
  int exp_sv    = 0;
  int exp_level = 0;
  int exp_perf  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every granted dcache transfer must be the next expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (store_valid_o) sv_count++;
      if (mem_req_o && mem_gnt_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: addr %h data %h, no transfer expected", mem_addr_o, mem_wdata_o);
        end else begin
          mon_e = exp_q.pop_front();
          if ({mem_addr_o, mem_wdata_o, mem_be_o} !== mon_e) begin
            errors++;
            $display("FAIL mem_xfer: got %h/%h/%h, expected %h/%h/%h", mem_addr_o, mem_wdata_o,
                     mem_be_o, mon_e[135:72], mon_e[71:8], mon_e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // The frame occupies the NW words directly below sp, word 0 lowest.
  function automatic logic [63:0] frame_addr(input logic [63:0] sp, input int i);
    return sp - 64'(NW * 8) + 64'(i * 8);
  endfunction

  // Hit when the offset's 8-byte slot is one of the NW slots starting at base.
  function automatic bit page_hit(input logic [63:0] base, input logic [11:0] off);
    int d;
    d = (int'(off >> 3) - int'(base[11:3]) + 512) % 512;
    return d < NW;
  endfunction

  function automatic logic [NW*XLEN-1:0] rand_data();
    logic [NW*XLEN-1:0] d;
    for (int i = 0; i < NW * 2; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_frame(input logic [63:0] sp, input logic [NW*XLEN-1:0] data, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({frame_addr(sp, i), data[i*64 +: 64], 8'hFF});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the frame to completion. mode 0: always granted, 1: random grants,
  // 2: grants withheld on SAVE cycles 3..5 (third word). restore_at pulses
  // restore_i on that cycle.
  task automatic wait_done(input logic [63:0] sp, input logic [NW*XLEN-1:0] data,
                           input int mode, input int exp_lat, input int restore_at);
    int lat;
    int lvl_before;
    lat = 0;
    lvl_before = exp_level;
    for (int n = 1; n <= 200; n++) begin
      if (mode == 1)      mem_gnt_i = 1'($urandom_range(0, 1));
      else if (mode == 2) mem_gnt_i = !(n >= 3 && n <= 5);
      else                mem_gnt_i = 1'b1;
      restore_i = (n == restore_at);
      @(negedge clk);
      if (mode == 2 && n >= 3 && n <= 5) begin
        check("stall_addr", mem_addr_o, frame_addr(sp, 2));
        check("stall_wdata", mem_wdata_o, data[2*64 +: 64]);
        check("stall_req", 64'(mem_req_o), 64'd1);
      end
      if (store_valid_o) lat = n;
      tick();
      if (lat != 0) break;
    end
    restore_i = 1'b0;
    mem_gnt_i = 1'b1;
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL save_timeout: got no store_valid, expected one within 200 cycles");
    end else begin
      if (exp_lat > 0) check("save_latency", 64'(lat), 64'(exp_lat));
      exp_sv++;
      exp_level = exp_level + 1;
      if (restore_at == lat && lvl_before > 0) exp_level = exp_level - 1;
    end
    check("level", 64'(level_o), 64'(exp_level));
    check("store_valid_count", 64'(sv_count), 64'(exp_sv));
    check("save_ready", 64'(save_ready_o), 64'(exp_level < MAXL));
  endtask

  task automatic run_save(input logic [63:0] sp, input logic [NW*XLEN-1:0] data,
                          input int mode, input int exp_lat, input int restore_at);
    push_frame(sp, data, NW);
    save_sp_i   = sp;
    save_data_i = data;
    save_req_i  = 1'b1;
    #1;
    check("next_sp", next_sp_o, sp - 64'(NW * 8));
    tick();
    save_req_i = 1'b0;
    wait_done(sp, data, mode, exp_lat, restore_at);
  endtask

  // ---------------- main stimulus ----------------
  logic [63:0] sp;
  logic [NW*XLEN-1:0] data;
  logic [63:0] lsu_a_addr, lsu_a_data, lsu_b_addr, lsu_b_data;
  logic [11:0] off;
  logic [11:0] dir_offs[5];

  initial begin
    rst = 1'b1;
    save_req_i = 1'b0; save_sp_i = '0; save_data_i = '0; restore_i = 1'b0;
    lsu_req_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_be_i = '0;
    mem_gnt_i = 1'b1; page_offset_i = 12'hFE0;
    repeat (3) tick();

    // Reset state
    check("rst_save_ready", 64'(save_ready_o), 64'd1);
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_store_valid", 64'(store_valid_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("rst_lsu_gnt", 64'(lsu_gnt_o), 64'd0);
    check("rst_perf", 64'(perf_lsu_stall_o), 64'd0);
    check("rst_page_match", 64'(page_offset_match_o), 64'd0);
    rst = 1'b0;
    tick();

    // Basic save, always granted
    run_save(64'h0000_0000_8000_1000, rand_data(), 0, 5, 0);

    // LSU contention: LSU store stalled when the trigger arrives
    sp = 64'h0000_0000_8000_2000;
    data = rand_data();
    lsu_a_addr = 64'h1234_5678_0000_0040; lsu_a_data = {$urandom, $urandom};
    lsu_b_addr = 64'h1234_5678_0000_0080; lsu_b_data = {$urandom, $urandom};
    exp_q.push_back({lsu_a_addr, lsu_a_data, 8'h0F});
    push_frame(sp, data, NW);
    exp_q.push_back({lsu_b_addr, lsu_b_data, 8'hF0});
    lsu_req_i = 1'b1; lsu_addr_i = lsu_a_addr; lsu_wdata_i = lsu_a_data; lsu_be_i = 8'h0F;
    mem_gnt_i = 1'b0;
    save_sp_i = sp; save_data_i = data; save_req_i = 1'b1;
    tick();
    save_req_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("pend_state", 64'(state_o), 64'(ST_PEND));
      check("pend_lsu_gnt", 64'(lsu_gnt_o), 64'd0);
      check("pend_passthru_addr", mem_addr_o, lsu_a_addr);
      tick();
    end
    mem_gnt_i = 1'b1;
    @(negedge clk);
    check("pend_lsu_granted", 64'(lsu_gnt_o), 64'd1);
    tick();
    lsu_addr_i = lsu_b_addr; lsu_wdata_i = lsu_b_data; lsu_be_i = 8'hF0;
    begin
      int lat;
      lat = 0;
      for (int n = 1; n <= 50; n++) begin
        @(negedge clk);
        if (store_valid_o) begin
          lat = n;
          check("done_lsu_gnt", 64'(lsu_gnt_o), 64'd1);
        end else begin
          check("save_state", 64'(state_o), 64'(ST_SAVE));
          check("save_lsu_gnt", 64'(lsu_gnt_o), 64'd0);
        end
        tick();
        if (lat != 0) break;
      end
      lsu_req_i = 1'b0;
      check("contention_latency", 64'(lat), 64'd5);
      if (lat != 0) begin exp_sv++; exp_level++; end
    end
`ifdef SHRU_SEQ_PERF_EN
    exp_perf = exp_perf + NW;
`endif
    check("perf", 64'(perf_lsu_stall_o), 64'(exp_perf));
    check("contention_level", 64'(level_o), 64'(exp_level));

    // Backpressure on the third word
    run_save(64'h0000_0000_4000_0800, rand_data(), 2, 8, 0);

    // Page match while a frame at 0xFE0 is stuck in SAVE
    sp = 64'h0000_0000_8000_1000;
    data = rand_data();
    push_frame(sp, data, NW);
    save_sp_i = sp; save_data_i = data; save_req_i = 1'b1;
    tick();
    save_req_i = 1'b0;
    mem_gnt_i = 1'b0;
    dir_offs[0] = 12'hFE8; dir_offs[1] = 12'hFD8; dir_offs[2] = 12'hFE0;
    dir_offs[3] = 12'hFFF; dir_offs[4] = 12'h000;
    for (int k = 0; k < 13; k++) begin
      off = (k < 5) ? dir_offs[k] : 12'(12'hFC0 + $urandom_range(0, 63));
      page_offset_i = off;
      #1;
      check("page_match_busy", 64'(page_offset_match_o), 64'(page_hit(sp - 64'(NW * 8), off)));
    end
    wait_done(sp, data, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      page_offset_i = 12'($urandom);
      #1;
      check("page_match_idle", 64'(page_offset_match_o), 64'd0);
    end

    // Nesting up to the limit with random grants
    while (exp_level < MAXL)
      run_save({32'h0, 20'($urandom), 12'h000} + 64'(($urandom_range(0, 511)) * 8), rand_data(), 1, 0, 0);
    check("max_level", 64'(level_o), 64'(MAXL));
    check("max_save_ready", 64'(save_ready_o), 64'd0);
    check("pre_overflow", 64'(overflow_o), 64'd0);
    save_sp_i = 64'h0000_0000_9000_0000; save_req_i = 1'b1;
    tick();
    save_req_i = 1'b0;
    repeat (3) tick();
    check("overflow_set", 64'(overflow_o), 64'd1);
    check("overflow_busy", 64'(busy_o), 64'd0);
    check("overflow_level", 64'(level_o), 64'(MAXL));
    restore_i = 1'b1;
    tick();
    restore_i = 1'b0;
    exp_level--;
    check("restore_level", 64'(level_o), 64'(exp_level));
    run_save(64'h0000_0000_8000_4000, rand_data(), 0, 5, 5);
    check("overflow_sticky", 64'(overflow_o), 64'd1);
    for (int k = 0; k < exp_level + 2; k++) begin
      restore_i = 1'b1;
      tick();
    end
    restore_i = 1'b0;
    exp_level = 0;
    check("restore_floor", 64'(level_o), 64'd0);

    // Reset after two granted words
    sp = 64'h0000_0000_8000_3000;
    data = rand_data();
    push_frame(sp, data, 2);
    save_sp_i = sp; save_data_i = data; save_req_i = 1'b1;
    tick();
    save_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_level", 64'(level_o), 64'd0);
    check("rst_mid_store_valid", 64'(store_valid_o), 64'd0);
    check("rst_mid_overflow", 64'(overflow_o), 64'd0);
    check("rst_mid_ready", 64'(save_ready_o), 64'd1);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("rst_mid_no_done", 64'(sv_count), 64'(exp_sv));
    check("rst_mid_perf", 64'(perf_lsu_stall_o), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
